// File: rtl/alsu_pipe.sv
// alsu_pipe: pipelined arithmetic/logic/shift unit with a valid/ready input handshake.
//
// Every op except MULT returns its result one edge after the accept. MULT runs an
// unsigned shift-add on |A| and |B| for WIDTH edges, then applies the sign on a
// final edge. While MULT runs, in_ready is low.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid, in_ready  input handshake; in_ready = idle && !rst
//   A, B                signed WIDTH-bit operands
//   cin, serial_in      carry-in for ADD; bit shifted in by SHIFT
//   red_op_A/B          reduce A or B (OR/XOR only)
//   opcode              0 OR, 1 XOR, 2 ADD, 3 MULT, 4 SHIFT, 5 ROTATE, 6/7 invalid
//   bypass_A/B          pass the sign-extended operand through to out
//   direction           1 = left, 0 = right (SHIFT/ROTATE)
//   out_valid, out      one-cycle result strobe; signed 2*WIDTH result, held between results
//   leds                invalid-op alarm pattern
//   busy                high while a MULT is in progress
//
// Optional build macro ALSU_STICKY_ALARM_EN: when defined, the first invalid result
// latches an alarm, and leds then toggle on every edge until reset.
module alsu_pipe #(
  parameter int unsigned WIDTH          = 3,
  parameter string       INPUT_PRIORITY = "A",
  parameter string       FULL_ADDER     = "ON",
  parameter int unsigned LED_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 cin,
  input  logic                 serial_in,
  input  logic                 red_op_A,
  input  logic                 red_op_B,
  input  logic [2:0]           opcode,
  input  logic                 bypass_A,
  input  logic                 bypass_B,
  input  logic                 direction,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   out,
  output logic [LED_W-1:0]     leds,
  output logic                 busy
);

  localparam int unsigned OW     = 2 * WIDTH;
  localparam int unsigned CW     = $clog2(WIDTH + 1);
  localparam bit          PRIO_A = (INPUT_PRIORITY == "A");
  localparam bit          FA_ON  = (FULL_ADDER == "ON");

  typedef enum logic [2:0] {
    OpOr, OpXor, OpAdd, OpMult, OpShift, OpRotate, OpInv6, OpInv7
  } opcode_e;

  typedef enum logic {StIdle, StMul} state_e;

  state_e            r_state;
  logic              r_vld;
  logic [WIDTH-1:0]  r_a, r_b;
  logic              r_cin, r_ser, r_red_a, r_red_b, r_byp_a, r_byp_b, r_dir;
  opcode_e           r_op;
  logic [CW-1:0]     r_cnt;
  logic [OW-1:0]     r_mcand, r_acc;
  logic [WIDTH-1:0]  r_mplier;
  logic              r_neg;
`ifdef ALSU_STICKY_ALARM_EN
  logic              r_alarm;
`endif

  logic              w_accept, w_go_mul, w_invalid, w_res_fire, w_res_inv, w_mul_done;
  logic              w_use_a_byp, w_use_a_red;
  logic [WIDTH-1:0]  w_abs_a, w_abs_b, w_red_opnd;
  logic [OW-1:0]     w_sext_a, w_sext_b, w_product, w_result;

  assign in_ready = (r_state == StIdle) && !rst;
  assign w_accept = in_valid && in_ready;
  // A MULT that would be overridden by bypass or flagged invalid by red_op takes the
  // single-cycle path instead of the multiplier.
  assign w_go_mul = w_accept && (opcode == OpMult) && !bypass_A && !bypass_B
                    && !red_op_A && !red_op_B;

  assign w_abs_a  = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
  assign w_abs_b  = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;

  assign w_sext_a    = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_sext_b    = {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_use_a_byp = r_byp_a && (!r_byp_b || PRIO_A);
  assign w_use_a_red = r_red_a && (!r_red_b || PRIO_A);
  assign w_red_opnd  = w_use_a_red ? r_a : r_b;
  assign w_product   = r_neg ? (~r_acc + OW'(1)) : r_acc;

  assign w_invalid  = (r_op == OpInv6) || (r_op == OpInv7) ||
                      ((r_red_a || r_red_b) && (r_op != OpOr) && (r_op != OpXor));
  assign w_mul_done = (r_state == StMul) && (r_cnt == '0);
  assign w_res_fire = ((r_state == StIdle) && r_vld) || w_mul_done;
  assign w_res_inv  = (r_state == StIdle) && r_vld && w_invalid;

  always_comb begin
    w_result = '0;
    if (w_invalid) begin
      w_result = '0;
    end else if (r_byp_a || r_byp_b) begin
      w_result = w_use_a_byp ? w_sext_a : w_sext_b;
    end else begin
      case (r_op)
        OpOr:     w_result = (r_red_a || r_red_b) ? OW'(|w_red_opnd) : (w_sext_a | w_sext_b);
        OpXor:    w_result = (r_red_a || r_red_b) ? OW'(^w_red_opnd) : (w_sext_a ^ w_sext_b);
        OpAdd:    w_result = w_sext_a + w_sext_b + OW'(FA_ON & r_cin);
        OpShift:  w_result = r_dir ? {out[OW-2:0], r_ser} : {r_ser, out[OW-1:1]};
        OpRotate: w_result = r_dir ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
        // MULT results come from the shift-add FSM and never reach this path.
        default:  w_result = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_vld     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_cin     <= 1'b0;
      r_ser     <= 1'b0;
      r_red_a   <= 1'b0;
      r_red_b   <= 1'b0;
      r_byp_a   <= 1'b0;
      r_byp_b   <= 1'b0;
      r_dir     <= 1'b0;
      r_op      <= OpOr;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplier  <= '0;
      r_neg     <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      leds      <= '0;
      busy      <= 1'b0;
`ifdef ALSU_STICKY_ALARM_EN
      r_alarm   <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      r_vld     <= w_accept && !w_go_mul;
      if (w_accept) begin
        r_a     <= A;
        r_b     <= B;
        r_cin   <= cin;
        r_ser   <= serial_in;
        r_red_a <= red_op_A;
        r_red_b <= red_op_B;
        r_byp_a <= bypass_A;
        r_byp_b <= bypass_B;
        r_dir   <= direction;
        r_op    <= opcode_e'(opcode);
      end

`ifdef ALSU_STICKY_ALARM_EN
      // leds stay zero until the first invalid result, then free-run until reset.
      if (r_alarm || (w_res_fire && w_res_inv)) leds <= ~leds;
      if (w_res_fire && w_res_inv) r_alarm <= 1'b1;
`else
      if (w_res_fire) leds <= w_res_inv ? ~leds : '0;
`endif

      case (r_state)
        StIdle: begin
          if (r_vld) begin
            out       <= w_result;
            out_valid <= 1'b1;
          end
          if (w_go_mul) begin
            r_state  <= StMul;
            busy     <= 1'b1;
            r_cnt    <= CW'(WIDTH);
            r_mcand  <= OW'(w_abs_a);
            r_mplier <= w_abs_b;
            r_acc    <= '0;
            r_neg    <= A[WIDTH-1] ^ B[WIDTH-1];
          end
        end
        StMul: begin
          if (r_cnt == '0) begin
            out       <= w_product;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            r_state   <= StIdle;
          end else begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
